// File: rtl/nic_inject_arbiter.sv
// Round-robin injection scheduler: N_REQ local requesters share one registered flit slot
// in front of the router NIC port. Define INJ_POLARITY_GATE_EN to gate launch on router polarity.
module nic_inject_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDW   = 2,
   parameter int unsigned CNTW  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [64*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]      req_ready,
   output logic                  nic_pesi,
   input  logic                  nic_peri,
   output logic [63:0]           nic_pedi,
   input  logic                  polarity,
   output logic [IDW-1:0]        grant_id,
   output logic [CNTW-1:0]       inj_count
);

   localparam int unsigned FLITW = 64;
   localparam int unsigned IDXW  = IDW + 1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state, state_d;
   logic [FLITW-1:0] slot_d;
   logic [IDW-1:0]   grant_d;
   logic [IDW-1:0]   rr_ptr, rr_d;
   logic [IDW-1:0]   winner;
   logic [CNTW-1:0]  cnt_d;
   logic [IDXW-1:0]  idx;
   logic [IDXW-1:0]  rr_inc;
   logic             found;
   logic             launch;
   logic             can_load;
   logic [FLITW-1:0] req_flit [N_REQ];

   for (genvar k = 0; k < N_REQ; k++) begin : g_flit
      assign req_flit[k] = req_data[FLITW*k +: FLITW];
   end

`ifdef INJ_POLARITY_GATE_EN
   // Hold the flit back while the router is using the VC it targets.
   assign nic_pesi = (state == FULL) && (polarity != nic_pedi[FLITW-1]);
`else
   logic unused_polarity;
   assign unused_polarity = polarity;
   assign nic_pesi        = (state == FULL);
`endif

   assign launch   = nic_pesi & nic_peri;
   assign can_load = (state == EMPTY) | launch;

   // First valid requester scanning upward from rr_ptr, modulo N_REQ.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         idx = IDXW'(rr_ptr) + IDXW'(i);
         if (idx >= IDXW'(N_REQ)) idx = idx - IDXW'(N_REQ);
         if (!found && req_valid[IDW'(idx)]) begin
            found  = 1'b1;
            winner = IDW'(idx);
         end
      end
   end

   always_comb begin
      state_d   = state;
      slot_d    = nic_pedi;
      grant_d   = grant_id;
      rr_d      = rr_ptr;
      cnt_d     = inj_count;
      req_ready = '0;
      rr_inc    = '0;
      if (launch) begin
         state_d = EMPTY;
         cnt_d   = inj_count + CNTW'(1);
      end
      // A launching slot may be refilled in the same cycle.
      if (can_load && found && !reset) begin
         req_ready[winner] = 1'b1;
         state_d           = FULL;
         slot_d            = req_flit[winner];
         grant_d           = winner;
         rr_inc            = IDXW'(winner) + IDXW'(1);
         rr_d              = (rr_inc == IDXW'(N_REQ)) ? '0 : IDW'(rr_inc);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= EMPTY;
         nic_pedi  <= '0;
         grant_id  <= '0;
         rr_ptr    <= '0;
         inj_count <= '0;
      end else begin
         state     <= state_d;
         nic_pedi  <= slot_d;
         grant_id  <= grant_d;
         rr_ptr    <= rr_d;
         inj_count <= cnt_d;
      end
   end

endmodule

// File: tb/tb_nic_inject_arbiter.sv
// Scoreboard bench for nic_inject_arbiter: the driver predicts each accept and queues the
// expected flit; a negedge monitor pops and compares on every launch.
module tb_nic_inject_arbiter;
   localparam int unsigned N    = 4;
   localparam int unsigned IDW  = 2;
   localparam int unsigned CNTW = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [N-1:0]      req_valid = '0;
   logic [64*N-1:0]   req_data = '0;
   logic [N-1:0]      req_ready;
   logic              nic_pesi;
   logic              nic_peri = 1'b0;
   logic [63:0]       nic_pedi;
   logic              polarity = 1'b0;
   logic [IDW-1:0]    grant_id;
   logic [CNTW-1:0]   inj_count;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [63:0]    data;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          checks = 0;
   int          failures = 0;
   logic [63:0] rd [N];
   bit          auto_data = 1'b1;
   int          cyc = 0;

   // reference model state
   bit              m_full = 1'b0;
   int              m_rr = 0;
   logic [CNTW-1:0] m_cnt = '0;
   logic            m_vc = 1'b0;

   nic_inject_arbiter #(.N_REQ(N), .IDW(IDW), .CNTW(CNTW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .nic_pesi  (nic_pesi),
      .nic_peri  (nic_peri),
      .nic_pedi  (nic_pedi),
      .polarity  (polarity),
      .grant_id  (grant_id),
      .inj_count (inj_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: drive inputs, check registered/comb outputs against the model, advance the model.
   task automatic step(input logic [N-1:0] v, input logic peri, input logic pol, input logic rst);
      logic         m_pesi;
      logic         m_launch;
      logic         found;
      int           win;
      logic [N-1:0] exp_ready;
      exp_t         e;
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < N; k++) begin
         if (auto_data) rd[k] = {8'(k + 1), 24'h0, 32'(cyc)};
         req_data[64*k +: 64] = rd[k];
      end
      req_valid = v;
      nic_peri  = peri;
      polarity  = pol;
      reset     = rst;
      #1;
      m_pesi = m_full;
`ifdef INJ_POLARITY_GATE_EN
      m_pesi = m_full && (pol != m_vc);
`endif
      chk("nic_pesi", 64'(nic_pesi), 64'(m_pesi));
      chk("inj_count", 64'(inj_count), 64'(m_cnt));
      m_launch = m_pesi && peri;
      found = 1'b0;
      win = 0;
      for (int i = 0; i < N; i++) begin
         int idx;
         idx = (m_rr + i) % N;
         if (!found && v[idx]) begin
            found = 1'b1;
            win = idx;
         end
      end
      exp_ready = '0;
      if (!rst && found && (!m_full || m_launch)) exp_ready[win] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      if (rst) begin
         m_full = 1'b0;
         m_rr   = 0;
         m_cnt  = '0;
         m_vc   = 1'b0;
         sb.delete();
      end else begin
         if (m_launch) begin
            m_cnt  = m_cnt + 1'b1;
            m_full = 1'b0;
         end
         if (exp_ready != '0) begin
            e.id   = IDW'(win);
            e.data = rd[win];
            sb.push_back(e);
            m_full = 1'b1;
            m_vc   = rd[win][63];
            m_rr   = (win + 1) % N;
         end
      end
   endtask

   // Monitor: every launch must match the oldest predicted accept.
   always @(negedge clk) begin
      if (!reset && nic_pesi && nic_peri) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL launch_unexpected: got data %h grant %0d expected no launch", nic_pedi, grant_id);
         end else begin
            mon_e = sb.pop_front();
            chk("launch_data", nic_pedi, mon_e.data);
            chk("launch_grant", 64'(grant_id), 64'(mon_e.id));
         end
      end
   end

   initial begin
      // Reset held two cycles with all requesters valid
      step(4'hF, 1'b0, 1'b0, 1'b1);
      step(4'hF, 1'b0, 1'b0, 1'b1);
      chk("reset_pedi", nic_pedi, 64'h0);
      chk("reset_grant", 64'(grant_id), 64'h0);

      // Round robin at full rate: grants 0,1,2,3,0,...
      for (int i = 0; i < 9; i++) step(4'hF, 1'b1, 1'b0, 1'b0);
      step(4'h0, 1'b0, 1'b0, 1'b0);
      chk("inj_count_8", 64'(inj_count), 64'd8);
      step(4'h0, 1'b1, 1'b0, 1'b0);
      step(4'h0, 1'b0, 1'b0, 1'b1);

      // Skip and wrap: rr_ptr reaches 3, then 0110 grants 1, then 2
      for (int i = 0; i < 3; i++) step(4'hF, 1'b1, 1'b0, 1'b0);
      step(4'b0110, 1'b1, 1'b0, 1'b0);
      step(4'b0110, 1'b1, 1'b0, 1'b0);
      step(4'h0, 1'b1, 1'b0, 1'b0);

      // Backpressure: slot held stable, then launch and reload together
      auto_data = 1'b0;
      for (int k = 0; k < N; k++) rd[k] = 64'h0;
      rd[0] = 64'hA5A5_0000_0000_0001;
      step(4'b0001, 1'b0, 1'b0, 1'b0);
      rd[0] = 64'h1234_5678_9ABC_DEF0;
      for (int i = 0; i < 5; i++) step(4'b0001, 1'b0, 1'b0, 1'b0);
      chk("bp_pedi_stable", nic_pedi, 64'hA5A5_0000_0000_0001);
      step(4'b0001, 1'b1, 1'b0, 1'b0);
      step(4'b0000, 1'b1, 1'b0, 1'b0);
      auto_data = 1'b1;

      // Mid-operation reset drops the held flit
      step(4'b0010, 1'b0, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      step(4'b0000, 1'b0, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b0, 1'b0);
      chk("midrst_pesi", 64'(nic_pesi), 64'h0);
      chk("midrst_count", 64'(inj_count), 64'h0);

      // Polarity toggling with VC bit 0: gated launch waits for polarity=1
      step(4'b0100, 1'b1, 1'b0, 1'b0);
      step(4'b0000, 1'b1, 1'b0, 1'b0);
      step(4'b0000, 1'b1, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b0, 1'b0);
      step(4'b0000, 1'b1, 1'b1, 1'b0);

      step(4'b0000, 1'b1, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b1, 1'b0);
      chk("sb_drained", 64'(sb.size()), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
